// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter between instruction fetch and MEM stage
// mem_req wins over if_req in IDLE; each access is split into 1/2/4 byte RAM cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic [31:0]           if_inst_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  input  logic [7:0]            ram_din_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic        owner_mem;
  logic [31:0] wdata;
  logic [31:0] data;
  logic [1:0]  lane;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    len_bytes = 3'd1;
      2'd1:    len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  // In READ, cnt runs one ahead of the lane because RAM data lags the address by a cycle
  assign lane        = 2'(cnt[1:0] - 2'd1);
  assign busy_o      = (state != IDLE);
  assign if_inst_o   = if_done_o  ? data : 32'd0;
  assign mem_rdata_o = mem_done_o ? data : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      owner_mem  <= 1'b0;
      wdata      <= 32'd0;
      data       <= 32'd0;
      ram_addr_o <= '0;
      ram_wr_o   <= 1'b0;
      ram_dout_o <= 8'd0;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            owner_mem  <= 1'b1;
            nbytes     <= len_bytes(mem_len_i);
            cnt        <= 3'd0;
            data       <= 32'd0;
            ram_addr_o <= mem_addr_i;
            if (mem_we_i) begin
              state      <= WRITE;
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
              wdata      <= mem_wdata_i >> 8;
            end else begin
              state <= READ;
            end
          end else if (if_req_i && !if_flush_i) begin
            owner_mem  <= 1'b0;
            nbytes     <= 3'd4;
            cnt        <= 3'd0;
            data       <= 32'd0;
            ram_addr_o <= if_addr_i;
            state      <= READ;
          end
        end
        READ: begin
          if (!owner_mem && if_flush_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            if (cnt != 3'd0) data[{lane, 3'b000} +: 8] <= ram_din_i;
            if (cnt == nbytes) begin
              state <= DONE;
              cnt   <= 3'd0;
              if (owner_mem) mem_done_o <= 1'b1;
              else           if_done_o  <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt + 3'd1 < nbytes) ram_addr_o <= ram_addr_o + ADDR_ONE;
            end
          end
        end
        WRITE: begin
          if (cnt + 3'd1 < nbytes) begin
            cnt        <= cnt + 3'd1;
            ram_addr_o <= ram_addr_o + ADDR_ONE;
            ram_dout_o <= wdata[7:0];
            wdata      <= wdata >> 8;
          end else begin
            ram_wr_o   <= 1'b0;
            ram_dout_o <= 8'd0;
            cnt        <= 3'd0;
            state      <= DONE;
            mem_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte RAM model
// Stimulus pushes expected completions; a negedge monitor pops and checks them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  ram_din = 8'd0;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic        busy;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_inst_o(if_inst), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .ram_din_i(ram_din), .ram_addr_o(ram_addr), .ram_wr_o(ram_wr),
    .ram_dout_o(ram_dout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:16383];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[13:0]] <= ram_dout;
    ram_din <= ram[ram_addr[13:0]];
  end

  typedef struct {
    bit          is_mem;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input bit m, input bit chk, input logic [31:0] d, input int c);
    exp_t e;
    e.is_mem = m; e.chk = chk; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (if_done === 1'b1 || mem_done === 1'b1) begin
      check("single_done", {30'd0, if_done, mem_done} == 32'd3, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: if_done=%b mem_done=%b cycle %0d", if_done, mem_done, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_src", {31'd0, mem_done}, {31'd0, e.is_mem});
        check("done_cycle", cyc, e.cyc);
        if (e.chk) check("done_data", e.is_mem ? mem_rdata : if_inst, e.data);
      end
    end
  end

  task automatic wait_done(input bit m, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m ? mem_done : if_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done within 30 cycles, expected one", nm);
    end
  endtask

  int c;

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    ram[14'h100] = 8'h13; ram[14'h101] = 8'h05; ram[14'h102] = 8'hA0; ram[14'h103] = 8'h00;
    ram[14'h2003] = 8'h55;
    ram[14'h040] = 8'h80;
    ram[14'h300] = 8'h11; ram[14'h301] = 8'h22; ram[14'h302] = 8'h33; ram[14'h303] = 8'h44;
    ram[14'h200] = 8'h93; ram[14'h201] = 8'h00; ram[14'h202] = 8'h10; ram[14'h203] = 8'h00;

    // reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_data", if_inst | mem_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word fetch
    c = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    push(1'b0, 1'b1, 32'h00A00513, c + 6);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("fetch_addr", ram_addr, 32'h100 + k - 1);
      check("fetch_wr", {31'd0, ram_wr}, 32'd0);
    end
    wait_done(1'b0, "fetch");
    if_req = 1'b0;
    @(negedge clk);

    // store half, unaligned
    c = cyc;
    mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h2001; mem_wdata = 32'hDEADBEEF; mem_req = 1'b1;
    push(1'b1, 1'b0, 32'd0, c + 3);
    @(negedge clk);
    check("st_c1_wr", {31'd0, ram_wr}, 32'd1);
    check("st_c1_addr", ram_addr, 32'h2001);
    check("st_c1_dout", {24'd0, ram_dout}, 32'hEF);
    @(negedge clk);
    check("st_c2_wr", {31'd0, ram_wr}, 32'd1);
    check("st_c2_addr", ram_addr, 32'h2002);
    check("st_c2_dout", {24'd0, ram_dout}, 32'hBE);
    wait_done(1'b1, "store");
    check("st_done_wr", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("st_ram_2001", {24'd0, ram[14'h2001]}, 32'hEF);
    check("st_ram_2002", {24'd0, ram[14'h2002]}, 32'hBE);
    check("st_ram_2003", {24'd0, ram[14'h2003]}, 32'h55);

    // load byte, zero-extended
    c = cyc;
    mem_len = 2'd0; mem_addr = 32'h40; mem_req = 1'b1;
    push(1'b1, 1'b1, 32'h00000080, c + 3);
    wait_done(1'b1, "ldb");
    mem_req = 1'b0;
    @(negedge clk);

    // contention: MEM word load first, IF the cycle after mem_done
    c = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    mem_len = 2'd2; mem_addr = 32'h300; mem_req = 1'b1;
    push(1'b1, 1'b1, 32'h44332211, c + 6);
    push(1'b0, 1'b1, 32'h00A00513, c + 13);
    wait_done(1'b1, "cont_mem");
    mem_req = 1'b0;
    wait_done(1'b0, "cont_if");
    if_req = 1'b0;
    @(negedge clk);

    // flush in cycle 3 of a fetch, then a clean fetch
    c = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    repeat (3) @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    if_flush = 1'b0; if_req = 1'b0;
    repeat (8) @(negedge clk);
    c = cyc;
    if_addr = 32'h200; if_req = 1'b1;
    push(1'b0, 1'b1, 32'h00100093, c + 6);
    wait_done(1'b0, "refetch");
    if_req = 1'b0;
    @(negedge clk);

    // reset in cycle 2 of a word store
    c = cyc;
    mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h3000; mem_wdata = 32'h11223344; mem_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_st_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_st_busy", {31'd0, busy}, 32'd0);
    check("rst_st_done", {31'd0, mem_done}, 32'd0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_st_3000", {24'd0, ram[14'h3000]}, 32'h44);
    check("rst_st_3001", {24'd0, ram[14'h3001]}, 32'h33);
    check("rst_st_3002", {24'd0, ram[14'h3002]}, 32'h00);
    check("pending_exp", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
